// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between the producers/FIFO side and fifo_write_arbiter.
//
// Handshake: a word of requester i moves when req_valid[i] and req_ready[i]
// are both high in the same write-clock cycle. The arbiter raises
// req_ready[i] only in the cycle it also raises write_enable with that word
// on wdata. The producer must hold req_data steady while valid is high and
// ready is low. wfull comes from the FIFO and blocks every transfer while high.
interface fifo_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) ();
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    wfull;
  logic                    write_enable;
  logic [DATA_W-1:0]       wdata;

  // Producers and FIFO flag side
  modport master (
    output req_valid, req_data, wfull,
    input  req_ready, write_enable, wdata
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, wfull,
    output req_ready, write_enable, wdata
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares the async FIFO write port among N_REQ
// producers. A grant lasts for up to MAX_BURST accepted words, then the
// priority pointer moves past the owner. There is one IDLE cycle between bursts.
// Optional feature macro: FIFO_ARB_CNT_EN adds saturating per-requester
// accepted-word counters on the word_cnt port.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_write_arbiter_if.slave     bus,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    dbg_state
`ifdef FIFO_ARB_CNT_EN
  ,
  output logic [N_REQ*CNT_W-1:0]  word_cnt
`endif
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  // Reject parameter sets the arbiter cannot support.
  if (N_REQ < 2 || MAX_BURST < 1 || CNT_W < 1) begin : g_bad_param
    $error("fifo_write_arbiter: unsupported parameters");
  end

  logic [0:0]        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [BEAT_W-1:0] beat;

  logic [PTR_W-1:0]  g_idx;
  logic [PTR_W-1:0]  pick_idx;
  logic              owner_valid;
  logic              xfer;
  logic              last_beat;
  logic              release_grant;

  // Find the first valid requester starting at rr_ptr and wrapping around.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    found    = 1'b0;
    pick_idx = '0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // Decode the one-hot grant into the owner index.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) g_idx = PTR_W'(i);
    end
  end

  // A word moves only while bursting, with the owner valid and the FIFO not full.
  always_comb begin
    owner_valid   = bus.req_valid[g_idx];
    xfer          = (state == BURST) && owner_valid && !bus.wfull;
    last_beat     = (beat == BEAT_W'(MAX_BURST - 1));
    release_grant = (state == BURST) && (!owner_valid || (xfer && last_beat));
  end

  // Drive the FIFO port and ready bits straight from the transfer decision.
  always_comb begin
    bus.write_enable = xfer;
    bus.req_ready    = xfer ? grant : '0;
    bus.wdata        = (state == BURST) ? bus.req_data[g_idx*DATA_W +: DATA_W] : '0;
    busy             = (state == BURST);
    dbg_state        = state;
  end

  // Two-state grant FSM; the priority pointer moves only when a grant is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant <= N_REQ'(1) << pick_idx;
            beat  <= '0;
            state <= BURST;
          end
        end
        default: begin
          if (xfer) beat <= beat + BEAT_W'(1);
          if (release_grant) begin
            rr_ptr <= (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
            grant  <= '0;
            beat   <= '0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef FIFO_ARB_CNT_EN
  logic [CNT_W-1:0] cnt [N_REQ];

  // Count accepted words per requester, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (xfer && grant[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    word_cnt = '0;
    for (int i = 0; i < N_REQ; i++) word_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=4).
// Compile with +define+FIFO_ARB_CNT_EN to also check the word counters.
module tb_fifo_write_arbiter;
  localparam int N_REQ     = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 16;

  logic clk;
  logic rst;
  logic [N_REQ-1:0] grant;
  logic busy;
  logic dbg_state;
`ifdef FIFO_ARB_CNT_EN
  logic [N_REQ*CNT_W-1:0] word_cnt;
`endif

  fifo_write_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  fifo_write_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .grant(grant),
    .busy(busy),
    .dbg_state(dbg_state)
`ifdef FIFO_ARB_CNT_EN
    ,
    .word_cnt(word_cnt)
`endif
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;
  end

  // Scoreboard state
  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One record per clock cycle: inputs held for the cycle, outputs expected mid-cycle.
  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic        wf;
    logic [31:0] data;
    logic [3:0]  g;
    logic        we;
    logic [7:0]  wd;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] rv, input logic wf,
                              input logic [31:0] data, input logic [3:0] g,
                              input logic we, input logic [7:0] wd, input logic b);
    vec_t v;
    v.rst = r; v.rv = rv; v.wf = wf; v.data = data;
    v.g = g; v.we = we; v.wd = wd; v.busy = b;
    vecs.push_back(v);
  endfunction

  // Driver: change inputs just after the rising edge, sample on the falling edge.
  task automatic drive(input logic r, input logic [3:0] rv, input logic wf, input logic [31:0] data);
    @(posedge clk);
    #1;
    rst           = r;
    bus.req_valid = rv;
    bus.wfull     = wf;
    bus.req_data  = data;
    @(negedge clk);
  endtask

  initial begin
    // Reset, then reset asserted in the middle of a burst
    add(1, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0001, 0, 32'h0000_0077, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0001, 0, 32'h0000_0077, 4'b0001, 1, 8'h77, 1);
    add(1, 4'b0001, 0, 32'h0000_0077, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 8'h00, 0);
    // Requester 1 alone with six words: burst of 4, bubble, burst of 2
    add(0, 4'b0010, 0, 32'h0000_1100, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0010, 0, 32'h0000_1100, 4'b0010, 1, 8'h11, 1);
    add(0, 4'b0010, 0, 32'h0000_1200, 4'b0010, 1, 8'h12, 1);
    add(0, 4'b0010, 0, 32'h0000_1300, 4'b0010, 1, 8'h13, 1);
    add(0, 4'b0010, 0, 32'h0000_1400, 4'b0010, 1, 8'h14, 1);
    add(0, 4'b0010, 0, 32'h0000_1500, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0010, 0, 32'h0000_1500, 4'b0010, 1, 8'h15, 1);
    add(0, 4'b0010, 0, 32'h0000_1600, 4'b0010, 1, 8'h16, 1);
    add(0, 4'b0000, 0, 32'h0000_0000, 4'b0010, 0, 8'h00, 1);
    add(0, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 8'h00, 0);
    // FIFO full for three cycles after the second word of a burst
    add(0, 4'b0001, 0, 32'h0000_0020, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0001, 0, 32'h0000_0020, 4'b0001, 1, 8'h20, 1);
    add(0, 4'b0001, 0, 32'h0000_0021, 4'b0001, 1, 8'h21, 1);
    add(0, 4'b0001, 1, 32'h0000_0022, 4'b0001, 0, 8'h22, 1);
    add(0, 4'b0001, 1, 32'h0000_0022, 4'b0001, 0, 8'h22, 1);
    add(0, 4'b0001, 1, 32'h0000_0022, 4'b0001, 0, 8'h22, 1);
    add(0, 4'b0001, 0, 32'h0000_0022, 4'b0001, 1, 8'h22, 1);
    add(0, 4'b0001, 0, 32'h0000_0023, 4'b0001, 1, 8'h23, 1);
    add(0, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 8'h00, 0);
    // Owner drops valid after two words; requester 1 idle so requester 2 is next
    add(1, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0101, 0, 32'h0050_0030, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0101, 0, 32'h0050_0030, 4'b0001, 1, 8'h30, 1);
    add(0, 4'b0101, 0, 32'h0050_0031, 4'b0001, 1, 8'h31, 1);
    add(0, 4'b0100, 0, 32'h0050_0000, 4'b0001, 0, 8'h00, 1);
    add(0, 4'b0100, 0, 32'h0050_0000, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0100, 0, 32'h0050_0000, 4'b0100, 1, 8'h50, 1);
    // Valid drop while the FIFO is full still releases
    add(0, 4'b0000, 1, 32'h0000_0000, 4'b0100, 0, 8'h00, 1);
    add(0, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [3:0] exp_ready;
      drive(vecs[i].rst, vecs[i].rv, vecs[i].wf, vecs[i].data);
      exp_ready = vecs[i].we ? vecs[i].g : 4'b0000;
      check($sformatf("v%0d grant", i),     32'(grant),            32'(vecs[i].g));
      check($sformatf("v%0d write_en", i),  32'(bus.write_enable), 32'(vecs[i].we));
      check($sformatf("v%0d wdata", i),     32'(bus.wdata),        32'(vecs[i].wd));
      check($sformatf("v%0d req_ready", i), 32'(bus.req_ready),    32'(exp_ready));
      check($sformatf("v%0d busy", i),      32'(busy),             32'(vecs[i].busy));
    end

    // All four continuously valid: three full rotations of 4-word bursts
    drive(1, 4'b0000, 0, 32'h0);
    for (int b = 0; b < 3 * N_REQ; b++) begin
      for (int w = 0; w < MAX_BURST; w++) exp_q.push_back(8'hA0 + 8'(b % N_REQ));
    end
    for (int b = 0; b < 3 * N_REQ; b++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (b % N_REQ);
      drive(0, 4'b1111, 0, 32'hA3A2_A1A0);
      check($sformatf("rr b%0d gap grant", b), 32'(grant), 32'h0);
      check($sformatf("rr b%0d gap we", b), 32'(bus.write_enable), 32'h0);
      for (int w = 0; w < MAX_BURST; w++) begin
        logic [7:0] exp_wd;
        drive(0, 4'b1111, 0, 32'hA3A2_A1A0);
        check($sformatf("rr b%0d w%0d grant", b, w), 32'(grant), 32'(exp_g));
        check($sformatf("rr b%0d w%0d we", b, w), 32'(bus.write_enable), 32'h1);
        check($sformatf("rr b%0d w%0d ready", b, w), 32'(bus.req_ready), 32'(exp_g));
        if (exp_q.size() == 0) begin
          check($sformatf("rr b%0d w%0d queue", b, w), 32'h0, 32'h1);
        end else begin
          exp_wd = exp_q.pop_front();
          check($sformatf("rr b%0d w%0d wdata", b, w), 32'(bus.wdata), 32'(exp_wd));
        end
      end
    end
    check("rr leftover", 32'(exp_q.size()), 32'h0);
    drive(0, 4'b0000, 0, 32'h0);
    check("rr end grant", 32'(grant), 32'h0);

`ifdef FIFO_ARB_CNT_EN
    for (int i = 0; i < N_REQ; i++) begin
      check($sformatf("cnt%0d after rotations", i), 32'(word_cnt[i*CNT_W +: CNT_W]), 32'd12);
    end
    drive(1, 4'b0000, 0, 32'h0);
    for (int i = 0; i < N_REQ; i++) begin
      check($sformatf("cnt%0d after rst", i), 32'(word_cnt[i*CNT_W +: CNT_W]), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
